// File: rtl/cic_comb_decimator_if.sv
// ---------------------------------------------------------------------------
// cic_comb_decimator_if
// Sample bus between an integrator chain and the comb/decimate stage, and
// from the comb/decimate stage to downstream DSP.
//
// Parameters:
//   W   input word width
//   OW  output word width
// Signals:
//   in         [W-1:0]   sample from the integrator chain
//   in_valid             in holds a new sample this cycle
//   out        [OW-1:0]  decimated, differentiated sample
//   out_valid            one-cycle strobe: out holds a new sample
// Modports:
//   master  sample source / result sink (testbench or upstream logic)
//   slave   the comb decimator itself
// ---------------------------------------------------------------------------
interface cic_comb_decimator_if #(
    parameter int W  = 32,
    parameter int OW = 32
);
    logic [W-1:0]  in;
    logic          in_valid;
    logic [OW-1:0] out;
    logic          out_valid;

    modport master (
        output in,
        output in_valid,
        input  out,
        input  out_valid
    );

    modport slave (
        input  in,
        input  in_valid,
        output out,
        output out_valid
    );
endinterface

// File: rtl/cic_comb_decimator.sv
// ---------------------------------------------------------------------------
// cic_comb_decimator
// Comb/decimate half of a CIC decimator. Keeps every R-th valid input
// sample, runs each kept sample through N cascaded comb stages
// y[n] = x[n] - x[n-M] (one register per stage), and presents the top OW
// bits of the last stage with a one-cycle valid strobe.
//
// Parameters:
//   W   input/internal width, all arithmetic wraps modulo 2^W
//   OW  output width (OW <= W), top OW bits of the stage-N result
//   N   number of comb stages (>= 1)
//   R   decimation ratio (>= 1, 1 = no decimation)
//   M   differential delay per stage (>= 1)
// Ports:
//   clk    single clock, all state on posedge
//   reset  synchronous, active-high; clears phase, stages, delay lines
//   bus    slave side of cic_comb_decimator_if (in, in_valid, out, out_valid)
//
// Optional feature macro: CIC_COMB_ROUND_EN
//   defined   -> out is rounded half-up before narrowing (wraps modulo 2^OW)
//   undefined -> the W-OW LSBs are truncated
//   The rounding add sits in front of the output register, so latency is
//   the same either way. With OW == W the macro has no effect.
// ---------------------------------------------------------------------------
module cic_comb_decimator #(
    parameter int W  = 32,
    parameter int OW = 32,
    parameter int N  = 3,
    parameter int R  = 8,
    parameter int M  = 1
) (
    input  logic              clk,
    input  logic              reset,
    cic_comb_decimator_if.slave bus
);

    // Phase counter width; a 1-bit counter that never leaves 0 when R == 1.
    localparam int PW = (R > 1) ? $clog2(R) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(R - 1);

`ifdef CIC_COMB_ROUND_EN
    // Half an output LSB, expressed at the internal width.
    localparam int RSH = (W > OW) ? (W - OW - 1) : 0;
    localparam logic [W-1:0] ROUND_HALF = (W > OW) ?
        ({{(W-1){1'b0}}, 1'b1} << RSH) : {W{1'b0}};
`endif

    logic [PW-1:0] phase_r;
    logic [W-1:0]  res_r  [N];
    logic [W-1:0]  dly_r  [N][M];
    logic [N-1:0]  vld_r;
    logic [OW-1:0] out_r;

    logic          keep_s;
    logic [W-1:0]  x_s    [N];
    logic [N-1:0]  v_s;
    logic [W-1:0]  diff_s [N];

    // Narrow a stage result to the output width (optionally rounded).
    function automatic logic [OW-1:0] narrow(input logic [W-1:0] v);
        logic [W-1:0] t;
        t = v;
`ifdef CIC_COMB_ROUND_EN
        t = v + ROUND_HALF;
`endif
        return t[W-1 -: OW];
    endfunction

    // Decimation decision and stage input/difference wiring.
    always_comb begin
        keep_s = bus.in_valid && (phase_r == PHASE_LAST);
        x_s[0] = bus.in;
        v_s[0] = keep_s;
        for (int k = 1; k < N; k++) begin
            x_s[k] = res_r[k-1];
            v_s[k] = vld_r[k-1];
        end
        // The oldest entry of each delay line is x[n-M] for that stage.
        for (int k = 0; k < N; k++) begin
            diff_s[k] = x_s[k] - dly_r[k][M-1];
        end
    end

    // Phase counter, comb stages, delay lines and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_r <= {PW{1'b0}};
            vld_r   <= {N{1'b0}};
            out_r   <= {OW{1'b0}};
            for (int k = 0; k < N; k++) begin
                res_r[k] <= {W{1'b0}};
                for (int j = 0; j < M; j++) begin
                    dly_r[k][j] <= {W{1'b0}};
                end
            end
        end else begin
            // Phase only moves on valid input; gaps leave it untouched.
            if (bus.in_valid) begin
                if (phase_r == PHASE_LAST) begin
                    phase_r <= {PW{1'b0}};
                end else begin
                    phase_r <= phase_r + PW'(1);
                end
            end else begin
                phase_r <= phase_r;
            end

            // A stage only computes and shifts its delay line when its input
            // is valid; idle cycles hold everything so the history stays in
            // sample time rather than clock time.
            for (int k = 0; k < N; k++) begin
                if (v_s[k]) begin
                    res_r[k]    <= diff_s[k];
                    dly_r[k][0] <= x_s[k];
                    for (int j = 1; j < M; j++) begin
                        dly_r[k][j] <= dly_r[k][j-1];
                    end
                    vld_r[k] <= 1'b1;
                end else begin
                    vld_r[k] <= 1'b0;
                end
            end

            // The output register is loaded in parallel with the last stage
            // so narrowing/rounding costs no extra cycle.
            if (v_s[N-1]) begin
                out_r <= narrow(diff_s[N-1]);
            end else begin
                out_r <= out_r;
            end
        end
    end

    assign bus.out       = out_r;
    assign bus.out_valid = vld_r[N-1];

endmodule

// File: tb/tb_cic_comb_decimator.sv
// ---------------------------------------------------------------------------
// tb_cic_comb_decimator
// Four differently configured comb decimators driven side by side. The
// reference model keeps the list of kept samples per instance and forms
// each expected output from the closed form of N cascaded combs:
//   y[n] = sum_{i=0..N} (-1)^i * C(N,i) * x[n - i*M]   (x before reset = 0)
// reduced modulo 2^W and narrowed to OW bits. Expected values and their
// arrival cycle are queued at stimulus time; a negedge monitor pops and
// compares on every strobe and checks that out holds between strobes.
//   inst 0: W=8  OW=8  N=1 R=1 M=1
//   inst 1: W=32 OW=32 N=3 R=1 M=2
//   inst 2: W=32 OW=20 N=3 R=4 M=2
//   inst 3: W=8  OW=4  N=1 R=1 M=1
// ---------------------------------------------------------------------------
module tb_cic_comb_decimator;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int p_w  [4] = '{8, 32, 32, 8};
    int p_ow [4] = '{8, 32, 20, 4};
    int p_n  [4] = '{1, 3, 3, 1};
    int p_r  [4] = '{1, 1, 4, 1};
    int p_m  [4] = '{1, 2, 2, 1};

    logic [31:0] din  [4];
    logic        dv   [4];
    logic [31:0] dout [4];
    logic        dvld [4];

    cic_comb_decimator_if #(.W(8),  .OW(8))  if_a ();
    cic_comb_decimator_if #(.W(32), .OW(32)) if_b ();
    cic_comb_decimator_if #(.W(32), .OW(20)) if_c ();
    cic_comb_decimator_if #(.W(8),  .OW(4))  if_d ();

    assign if_a.in = din[0][7:0];  assign if_a.in_valid = dv[0];
    assign if_b.in = din[1];       assign if_b.in_valid = dv[1];
    assign if_c.in = din[2];       assign if_c.in_valid = dv[2];
    assign if_d.in = din[3][7:0];  assign if_d.in_valid = dv[3];

    assign dout[0] = {24'd0, if_a.out};  assign dvld[0] = if_a.out_valid;
    assign dout[1] = if_b.out;           assign dvld[1] = if_b.out_valid;
    assign dout[2] = {12'd0, if_c.out};  assign dvld[2] = if_c.out_valid;
    assign dout[3] = {28'd0, if_d.out};  assign dvld[3] = if_d.out_valid;

    cic_comb_decimator #(.W(8),  .OW(8),  .N(1), .R(1), .M(1)) u_a (.clk(clk), .reset(rst), .bus(if_a));
    cic_comb_decimator #(.W(32), .OW(32), .N(3), .R(1), .M(2)) u_b (.clk(clk), .reset(rst), .bus(if_b));
    cic_comb_decimator #(.W(32), .OW(20), .N(3), .R(4), .M(2)) u_c (.clk(clk), .reset(rst), .bus(if_c));
    cic_comb_decimator #(.W(8),  .OW(4),  .N(1), .R(1), .M(1)) u_d (.clk(clk), .reset(rst), .bus(if_d));

    longint hist     [4][$];
    longint expq     [4][$];
    int     expc     [4][$];
    int     vcount   [4];
    longint last_out [4];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int d, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0d, expected %0d (cycle %0d)", name, d, act, exp, cyc);
        end
    endtask

    function automatic longint wmask(input int w);
        return (longint'(1) << w) - 1;
    endfunction

    // Closed-form N-stage comb over the kept-sample history.
    function automatic longint comb_ref(input int d);
        longint s = 0;
        longint c = 1;
        int     n = p_n[d];
        int     idx;
        for (int i = 0; i <= n; i++) begin
            idx = hist[d].size() - 1 - i * p_m[d];
            if (idx >= 0) begin
                if (i % 2 == 1) s = s - c * hist[d][idx];
                else            s = s + c * hist[d][idx];
            end
            c = c * (n - i) / (i + 1);
        end
        return s & wmask(p_w[d]);
    endfunction

    function automatic longint narrow_ref(input longint v, input int d);
        longint t = v;
        int     sh = p_w[d] - p_ow[d];
`ifdef CIC_COMB_ROUND_EN
        if (sh > 0) t = (t + (longint'(1) << (sh - 1))) & wmask(p_w[d]);
`endif
        return t >> sh;
    endfunction

    function automatic int pending();
        int s = 0;
        for (int d = 0; d < 4; d++) s += expq[d].size();
        return s;
    endfunction

    // Record this cycle's accepted inputs in the model, then advance a cycle.
    task automatic tick();
        if (!rst) begin
            for (int d = 0; d < 4; d++) begin
                if (dv[d]) begin
                    vcount[d]++;
                    if (vcount[d] % p_r[d] == 0) begin
                        hist[d].push_back(longint'(din[d]) & wmask(p_w[d]));
                        expq[d].push_back(narrow_ref(comb_ref(d), d));
                        expc[d].push_back(cyc + p_n[d]);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) dv[d] = 1'b0;
    endtask

    // One-cycle reset with inputs valid; everything in flight is dropped.
    task automatic do_reset();
        rst = 1'b1;
        for (int d = 0; d < 4; d++) begin
            hist[d].delete();
            expq[d].delete();
            expc[d].delete();
            vcount[d] = 0;
            dv[d]     = 1'b1;
            din[d]    = $urandom;
        end
        tick();
        rst = 1'b0;
    endtask

    // Monitor: pop and compare on each strobe, check hold otherwise.
    initial begin
        longint e;
        int     ec;
        for (int d = 0; d < 4; d++) last_out[d] = 0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if (rst) begin
                    last_out[d] = 0;
                end else if (dvld[d] === 1'b1) begin
                    if (expq[d].size() == 0) begin
                        check("unexpected_strobe", d, 1, 0);
                    end else begin
                        e  = expq[d].pop_front();
                        ec = expc[d].pop_front();
                        check("out_value", d, longint'(dout[d]), e);
                        check("latency", d, cyc, ec);
                        last_out[d] = e;
                    end
                end else begin
                    check("out_hold", d, longint'(dout[d]), last_out[d]);
                    check("valid_low", d, longint'(dvld[d]), 0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ta [5] = '{5, 7, 10, 250, 4};
        logic [7:0] acc;
        rst = 1'b1;
        for (int d = 0; d < 4; d++) begin
            din[d]    = 32'd0;
            dv[d]     = 1'b0;
            vcount[d] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed: basic sequence + wrap (0), impulse (1),
        // decimation with gaps (2), rounding (3).
        for (int i = 0; i < 16; i++) begin
            if (i < 5) begin din[0] = ta[i]; dv[0] = 1'b1; end
            din[1] = (i == 0) ? 32'd1 : 32'd0;
            dv[1]  = 1'b1;
            if (i % 2 == 0) begin din[2] = i / 2 + 1; dv[2] = 1'b1; end
            if (i < 2) begin din[3] = (i == 1) ? 32'h18 : 32'h0; dv[3] = 1'b1; end
            tick();
        end
        repeat (8) tick();

        // Cascade: wrapping accumulator of constant 3 feeding instance 0.
        acc = 8'd0;
        for (int i = 0; i < 30; i++) begin
            acc    = acc + 8'd3;
            din[0] = {24'd0, acc};
            dv[0]  = 1'b1;
            tick();
        end

        // Random traffic with gaps, one reset in the middle.
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                do_reset();
            end else begin
                for (int d = 0; d < 4; d++) begin
                    dv[d]  = ($urandom_range(0, 9) < 6);
                    din[d] = $urandom;
                end
                tick();
            end
        end

        // Drain with a bounded wait.
        for (int k = 0; k < 40 && pending() != 0; k++) tick();
        for (int d = 0; d < 4; d++) check("drained", d, longint'(expq[d].size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
